// File: rtl/imem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : imem_arbiter_if
// Description : Fetch/debug request-response bundle plus the ROM read port.
// Revision    : 1.0 - initial release
// ============================================================================
interface imem_arbiter_if;
    logic        f_req;
    logic [31:0] f_addr;
    logic        f_gnt;
    logic        f_valid;
    logic [31:0] f_data;
    logic        f_err;

    logic        d_req;
    logic [31:0] d_addr;
    logic        d_gnt;
    logic        d_valid;
    logic [31:0] d_data;
    logic        d_err;

    logic [31:0] rom_addr;
    logic [31:0] rom_data;

    // master: requesters and ROM around the arbiter; slave: the arbiter itself
    modport master (
        output f_req, f_addr, d_req, d_addr, rom_data,
        input  f_gnt, f_valid, f_data, f_err,
        input  d_gnt, d_valid, d_data, d_err, rom_addr
    );

    modport slave (
        input  f_req, f_addr, d_req, d_addr, rom_data,
        output f_gnt, f_valid, f_data, f_err,
        output d_gnt, d_valid, d_data, d_err, rom_addr
    );
endinterface
`default_nettype wire

// File: rtl/imem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : imem_arbiter
// Description : Fetch-priority ROM port arbiter with debug starvation guard,
//               address decode and one-cycle registered responses.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_arbiter #(
    parameter logic [24:0] BASE_ADDRESS = 25'd0,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  wire logic       clk,
    input  wire logic       reset_n,
    imem_arbiter_if.slave   bus
);

    localparam logic [3:0] c_starve_limit = 4'(STARVE_LIMIT);

    logic [3:0]  r_starve_cnt;
    logic        w_force;
    logic        w_f_gnt;
    logic        w_d_gnt;
    logic [31:0] w_rom_addr;
    logic        w_err;

    logic        r_f_valid;
    logic [31:0] r_f_data;
    logic        r_f_err;
    logic        r_d_valid;
    logic [31:0] r_d_data;
    logic        r_d_err;

    // Force is taken straight from the counter so it applies on the very next
    // arbitration after the limit-th loss.
    assign w_force    = (r_starve_cnt == c_starve_limit);
    assign w_d_gnt    = bus.d_req && (!bus.f_req || w_force);
    assign w_f_gnt    = bus.f_req && !w_d_gnt;
    assign w_rom_addr = w_d_gnt ? bus.d_addr : bus.f_addr;
    assign w_err      = (w_rom_addr[1:0] != 2'b00) ||
                        (w_rom_addr[31:7] != BASE_ADDRESS);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_starve_cnt <= 4'd0;
            r_f_valid    <= 1'b0;
            r_f_data     <= 32'h0;
            r_f_err      <= 1'b0;
            r_d_valid    <= 1'b0;
            r_d_data     <= 32'h0;
            r_d_err      <= 1'b0;
        end else begin
            if (!bus.d_req || w_d_gnt) begin
                r_starve_cnt <= 4'd0;
            end else if (r_starve_cnt != c_starve_limit) begin
                r_starve_cnt <= r_starve_cnt + 4'd1;
            end

            r_f_valid <= w_f_gnt;
            if (w_f_gnt) begin
                r_f_err  <= w_err;
                r_f_data <= w_err ? 32'h0 : bus.rom_data;
            end

            r_d_valid <= w_d_gnt;
            if (w_d_gnt) begin
                r_d_err  <= w_err;
                r_d_data <= w_err ? 32'h0 : bus.rom_data;
            end
        end
    end

    assign bus.f_gnt    = w_f_gnt;
    assign bus.d_gnt    = w_d_gnt;
    assign bus.rom_addr = w_rom_addr;
    assign bus.f_valid  = r_f_valid;
    assign bus.f_data   = r_f_data;
    assign bus.f_err    = r_f_err;
    assign bus.d_valid  = r_d_valid;
    assign bus.d_data   = r_d_data;
    assign bus.d_err    = r_d_err;

endmodule
`default_nettype wire

// File: doc/imem_arbiter.md
Name: imem_arbiter

Overview:
- Shares the single combinational instruction ROM read port between two requesters: the pipeline fetch stage (F) and the debug/test read port (D).
- Fetch normally has priority. A starvation counter forces a debug grant after a bounded wait.
- Decodes each granted address for alignment and for the ROM window. It returns a registered response (data + valid + error) one cycle after the grant.
- Sits between the IF stage / debug unit and the ROM.

Parameters:
- BASE_ADDRESS, 25'd0, value of address[31:7] that selects the ROM window.
- STARVE_LIMIT, 4, cycles D may lose arbitration before D is forced to win (range 1..15).

Ports:
- clk  input  1  system clock, rising edge
- reset_n  input  1  asynchronous active-low reset
- f_req  input  1  fetch read request
- f_addr  input  32  fetch byte address
- f_gnt  output  1  fetch granted this cycle (combinational)
- f_valid  output  1  fetch response valid (registered)
- f_data  output  32  fetch response data (registered)
- f_err  output  1  fetch response error (registered)
- d_req  input  1  debug read request
- d_addr  input  32  debug byte address
- d_gnt  output  1  debug granted this cycle (combinational)
- d_valid  output  1  debug response valid (registered)
- d_data  output  32  debug response data (registered)
- d_err  output  1  debug response error (registered)
- rom_addr  output  32  address driven to the ROM (combinational mux)
- rom_data  input  32  ROM read data, combinational from rom_addr

Behaviour:
- Reset (reset_n low, asynchronous):
  - f_valid, d_valid, f_err, d_err = 0.
  - f_data, d_data = 32'h0.
  - Starvation counter = 0; force flag = 0.
- Handshake:
  - A requester holds req high and addr stable until it sees gnt high on a rising edge.
  - Exactly one transfer occurs per grant.
  - A requester may lower req without a grant; no penalty.
- Arbitration (combinational, per cycle):
  - Only f_req: F wins.
  - Only d_req: D wins.
  - Both, force flag 0: F wins. Both, force flag 1: D wins.
  - Neither: no grant; rom_addr = f_addr.
  - f_gnt and d_gnt are never both 1.
- rom_addr = winner's address.
- Starvation counter (4-bit):
  - Increments on each edge where d_req=1 and d_gnt=0, saturating at STARVE_LIMIT.
  - Clears to 0 on any edge with d_gnt=1 or d_req=0.
  - Force flag = (counter == STARVE_LIMIT).
- Error decode on the granted address:
  - err = (address[1:0] != 0) OR (address[31:7] != BASE_ADDRESS).
- Response, at the rising edge where a grant is active:
  - Winner's valid <= 1.
  - Winner's err <= decoded err.
  - Winner's data <= rom_data if no error, else 32'h0.
  - Loser's valid <= 0; its data and err hold their previous values.
- Response latency: exactly 1 cycle after the grant edge. A valid pulse lasts one cycle unless granted again.
- Back-to-back grants to the same requester give a valid response every cycle (full throughput).
- Without a grant, valid <= 0 and data/err hold.
- Simultaneous events:
  - Counter clear has precedence over increment.
  - Force takes effect in the same cycle the counter reaches STARVE_LIMIT, i.e. the next arbitration after the STARVE_LIMIT-th loss.
- Reset mid-transfer: any pending response is discarded (valid forced 0). Requesters must re-request after reset deasserts.
- X-safety: if rom_data is X on a granted, error-free read, data propagates X. No assertion is required, but the bench flags it.

Test Plan:
- Reset, then F reads 0x0 and 0x4 back-to-back with d_req=0, rom_data returning 32'h20090000 then 32'h21290005:
  - f_gnt=1 on both cycles.
  - f_valid=1 on the two following cycles with f_data=20090000, 21290005; f_err=0.
- D-only read of 0x0C, rom_data=32'h1429fffd -> d_gnt=1, then next cycle d_valid=1, d_data=1429fffd, d_err=0; f_valid stays 0.
- F and D both request continuously, STARVE_LIMIT=4:
  - F is granted 4 cycles, D is granted on the 5th, then F resumes.
  - The pattern repeats with period 5; the counter returns to 0 after each D grant.
- Error cases:
  - F reads 0x06 (unaligned) -> f_valid=1, f_err=1, f_data=0.
  - D reads 0x80 (outside window, BASE_ADDRESS=0) -> d_valid=1, d_err=1, d_data=0.
- Reset mid-operation: assert reset_n low asynchronously between edges while f_valid=1 and the counter=3 -> f_valid, d_valid immediately 0 and the counter is 0. After release, contention again yields 4 F grants before a D grant.
- Mutual exclusion under randomised f_req/d_req for 1000 cycles -> f_gnt&d_gnt never 1, and every grant is followed by exactly one valid on the matching side.
